d_write_buffer: RTL and testbench
=================================

D_WRITE_BUFFER -- requirements
Module: d_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of store entries; power of two, 2..16.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1: reset, synchronous, active-low.
REQ-004 SHALL have ports cpu_data_req in 1, cpu_data_wr in 1, cpu_data_size in 2, cpu_data_addr in 32, cpu_data_wdata in 32: upstream sram-like request from the write-through d-cache.
REQ-005 SHALL have ports cpu_data_rdata out 32, cpu_data_addr_ok out 1, cpu_data_data_ok out 1: upstream sram-like response.
REQ-006 SHALL have ports mem_data_req out 1, mem_data_wr out 1, mem_data_size out 2, mem_data_addr out 32, mem_data_wdata out 32: downstream sram-like request to the AXI bridge data port.
REQ-007 SHALL have ports mem_data_rdata in 32, mem_data_addr_ok in 1, mem_data_data_ok in 1: downstream sram-like response.
REQ-008 SHALL have ports wb_empty out 1, wb_full out 1: status; wb_empty high when FIFO count is 0 and the FSM is IDLE.

Function
REQ-009 SHALL hold a circular FIFO of DEPTH entries {addr[31:0], wdata[31:0], size[1:0]}, with head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH and a count of log2(DEPTH)+1 bits.
REQ-010 SHALL allow at most one outstanding upstream transaction: no new cpu_data_addr_ok until the previous transaction's cpu_data_data_ok has been issued.
REQ-011 Upstream write: SHALL assert cpu_data_addr_ok combinationally when cpu_data_req & cpu_data_wr & registered count<DEPTH & no upstream transaction pending; the push occurs on that edge.
REQ-012 Upstream write: SHALL assert cpu_data_data_ok for exactly one cycle, the cycle after the push, with cpu_data_rdata = 0.
REQ-013 Upstream read: SHALL assert cpu_data_addr_ok only when cpu_data_req & ~cpu_data_wr & count==0 & FSM==IDLE & no upstream transaction pending; reads never bypass buffered stores.
REQ-014 Downstream FSM states SHALL be IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
REQ-015 From IDLE: an accepted upstream read -> RD_REQ (the address and size are latched); else count>0 -> WR_REQ; else stay IDLE. An accepted read cannot coincide with count>0.
REQ-016 In WR_REQ: mem_data_req=1, mem_data_wr=1, and addr/wdata/size SHALL come from the head entry; on mem_data_addr_ok -> WR_WAIT.
REQ-017 In WR_WAIT: mem_data_req=0; on mem_data_data_ok, pop the head and go to WR_REQ if the post-pop count>0, else IDLE.
REQ-018 In RD_REQ: mem_data_req=1, mem_data_wr=0, using the latched addr/size; on mem_data_addr_ok -> RD_WAIT.
REQ-019 In RD_WAIT: on mem_data_data_ok, cpu_data_data_ok=1 and cpu_data_rdata=mem_data_rdata in the same cycle (combinational pass-through); -> IDLE.
REQ-020 mem_data_req SHALL be 0 in IDLE, WR_WAIT and RD_WAIT; at most one downstream transaction is outstanding.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged and advance both pointers; admission uses the pre-edge count, so a full FIFO rejects a push even in a pop cycle.
REQ-022 A push into an empty FIFO SHALL reach the head no earlier than the next cycle; WR_REQ is entered the cycle after the push.
REQ-023 wb_full SHALL equal (count==DEPTH).
REQ-024 Stores SHALL reach memory in acceptance order, and each store SHALL be issued downstream exactly once.

Reset
REQ-025 While resetn==0 at a clock edge: FSM=IDLE, head=tail=0, count=0, upstream pending flag=0, latched read addr/size=0.
REQ-026 After reset, outputs SHALL be: cpu_data_addr_ok=0 (unless the REQ-011/013 conditions hold), cpu_data_data_ok=0, cpu_data_rdata=0, mem_data_req=0, mem_data_wr=0, mem_data_addr/wdata/size=0, wb_empty=1, wb_full=0.
REQ-027 Reset asserted mid-transaction SHALL discard all buffered entries and any outstanding downstream transaction without issuing data_ok; the environment also resets the downstream port.

Verification
REQ-028 Single store: write addr 0x1000_0010, data 0xDEAD_BEEF, size 2 -> addr_ok in cycle 0, cpu data_ok in cycle 1, mem_data_req=1 with the same addr/data in cycle 2, wb_empty=1 after mem data_ok.
REQ-029 Fill: with mem_data_addr_ok held 0, issue 5 stores -> 4 accepted, wb_full=1, the 5th store's addr_ok stays 0 until the first mem handshake completes.
REQ-030 Read-after-write: store 0x55 to 0x20, then read 0x20 -> the read addr_ok is withheld until the store's mem data_ok; the read is issued downstream afterwards and returns the memory value 0x55.
REQ-031 Ordering: stores A, B, C to distinct addresses with random mem latencies 0-5 cycles -> downstream writes appear in order A, B, C, each exactly once.
REQ-032 Simultaneous push/pop at count=2 -> count stays 2 and the head/tail pointers wrap correctly past DEPTH-1 to 0.
REQ-033 Reset asserted in WR_WAIT with 3 entries buffered -> next cycle count=0, FSM=IDLE, mem_data_req=0, no cpu_data_data_ok.

Source files
------------

// File: rtl/d_write_buffer.sv
// Write buffer between a write-through d-cache and the AXI bridge data port.
// Stores are queued and drained in order; reads wait until every buffered store has completed.
module d_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        mem_data_req,
  output logic        mem_data_wr,
  output logic [1:0]  mem_data_size,
  output logic [31:0] mem_data_addr,
  output logic [31:0] mem_data_wdata,
  input  logic [31:0] mem_data_rdata,
  input  logic        mem_data_addr_ok,
  input  logic        mem_data_data_ok,
  output logic        wb_empty,
  output logic        wb_full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } wb_entry_t;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

  wb_entry_t     fifo [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count, count_nxt;
  state_t        state;
  logic          up_pend, wr_dok;
  logic [31:0]   rd_addr;
  logic [1:0]    rd_size;
  logic          wr_acc, rd_acc, push, pop, rd_done;

  // Admission always looks at the registered count, so a full FIFO refuses a push even while popping.
  assign wr_acc  = cpu_data_req & cpu_data_wr & (count < FULL_CNT) & ~up_pend;
  assign rd_acc  = cpu_data_req & ~cpu_data_wr & (count == '0) & (state == IDLE) & ~up_pend;
  assign push    = wr_acc;
  assign pop     = (state == WR_WAIT) & mem_data_data_ok;
  assign rd_done = (state == RD_WAIT) & mem_data_data_ok;

  assign count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  assign cpu_data_addr_ok = wr_acc | rd_acc;
  assign cpu_data_data_ok = wr_dok | rd_done;
  assign cpu_data_rdata   = rd_done ? mem_data_rdata : '0;

  assign wb_empty = (count == '0) & (state == IDLE);
  assign wb_full  = (count == FULL_CNT);

  always_comb begin
    mem_data_req   = 1'b0;
    mem_data_wr    = 1'b0;
    mem_data_addr  = '0;
    mem_data_wdata = '0;
    mem_data_size  = '0;
    case (state)
      WR_REQ: begin
        mem_data_req   = 1'b1;
        mem_data_wr    = 1'b1;
        mem_data_addr  = fifo[head].addr;
        mem_data_wdata = fifo[head].wdata;
        mem_data_size  = fifo[head].size;
      end
      RD_REQ: begin
        mem_data_req  = 1'b1;
        mem_data_addr = rd_addr;
        mem_data_size = rd_size;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= '{addr: cpu_data_addr, wdata: cpu_data_wdata, size: cpu_data_size};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      up_pend <= 1'b0;
      wr_dok  <= 1'b0;
      rd_addr <= '0;
      rd_size <= '0;
    end else begin
      count  <= count_nxt;
      wr_dok <= push;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (cpu_data_addr_ok)      up_pend <= 1'b1;
      else if (cpu_data_data_ok) up_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_acc) begin
            state   <= RD_REQ;
            rd_addr <= cpu_data_addr;
            rd_size <= cpu_data_size;
          end else if (count != '0) begin
            state <= WR_REQ;
          end
        end
        WR_REQ:  if (mem_data_addr_ok) state <= WR_WAIT;
        WR_WAIT: if (mem_data_data_ok) state <= (count_nxt != '0) ? WR_REQ : IDLE;
        RD_REQ:  if (mem_data_addr_ok) state <= RD_WAIT;
        RD_WAIT: if (mem_data_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_d_write_buffer.sv
// Randomized bench for d_write_buffer: a transaction-level model of the buffer plus a
// random-latency memory responder; every cycle the DUT's handshakes are checked against the model.
module tb_d_write_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_data_req, cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic        mem_data_req, mem_data_wr;
  logic [1:0]  mem_data_size;
  logic [31:0] mem_data_addr, mem_data_wdata, mem_data_rdata;
  logic        mem_data_addr_ok, mem_data_data_ok;
  logic        wb_empty, wb_full;

  always #5 clk = ~clk;

  d_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr), .cpu_data_size(cpu_data_size),
    .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
    .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
    .mem_data_req(mem_data_req), .mem_data_wr(mem_data_wr), .mem_data_size(mem_data_size),
    .mem_data_addr(mem_data_addr), .mem_data_wdata(mem_data_wdata), .mem_data_rdata(mem_data_rdata),
    .mem_data_addr_ok(mem_data_addr_ok), .mem_data_data_ok(mem_data_data_ok),
    .wb_empty(wb_empty), .wb_full(wb_full)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  // Model: stores accepted but not yet issued, outstanding store count, upstream/read/downstream flags.
  st_t         mq[$];
  logic [31:0] mem_model [logic [31:0]];
  int          mcount = 0, prev_mcount = 0;
  bit          mpend = 0, wr_dok_m = 0, rd_busy = 0, out = 0, out_wr = 0;
  logic [31:0] rd_addr_m = '0, last_rdata = '0;
  logic [1:0]  rd_size_m = '0;
  bit          exp_ok, exp_dok, exp_req, acc;
  st_t         st;

  function automatic logic [31:0] memget(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      mq.delete();
      mcount = 0; prev_mcount = 0;
      mpend = 0; wr_dok_m = 0; rd_busy = 0; out = 0;
    end else begin
      exp_ok = cpu_data_req && !mpend && (cpu_data_wr ? (mcount < DEPTH) : (mcount == 0));
      chk("addr_ok", cpu_data_addr_ok, exp_ok);
      chk("wb_full", wb_full, mcount == DEPTH);
      chk("wb_empty", wb_empty, mcount == 0 && !rd_busy);
      exp_dok = wr_dok_m || (rd_busy && out && mem_data_data_ok);
      chk("data_ok", cpu_data_data_ok, exp_dok);
      if (wr_dok_m) chk("wr_rdata", cpu_data_rdata, 32'h0);
      else if (exp_dok) chk("rd_rdata", cpu_data_rdata, memget(rd_addr_m));
      exp_req = !out && (rd_busy || (mcount > 0 && prev_mcount > 0));
      chk("mem_req", mem_data_req, exp_req);
      if (mem_data_req && mem_data_addr_ok) begin
        chk("mem_wr", mem_data_wr, !rd_busy);
        if (mem_data_wr) begin
          if (mq.size() == 0) chk("wr_extra", mem_data_req, 1'b0);
          else begin
            st = mq.pop_front();
            chk("wr_addr", mem_data_addr, st.addr);
            chk("wr_data", mem_data_wdata, st.data);
            chk("wr_size", mem_data_size, st.size);
          end
        end else begin
          chk("rd_addr", mem_data_addr, rd_addr_m);
          chk("rd_size", mem_data_size, rd_size_m);
        end
      end
      // advance the model past the coming edge
      acc = cpu_data_req && cpu_data_addr_ok;
      prev_mcount = mcount;
      if (wr_dok_m) mpend = 0;
      if (rd_busy && out && mem_data_data_ok) begin
        rd_busy = 0; mpend = 0; last_rdata = cpu_data_rdata;
      end
      if (out && mem_data_data_ok) begin
        out = 0;
        if (out_wr) mcount--;
      end else if (mem_data_req && mem_data_addr_ok) begin
        out = 1; out_wr = mem_data_wr;
      end
      wr_dok_m = acc && cpu_data_wr;
      if (acc && cpu_data_wr) begin
        mq.push_back('{addr: cpu_data_addr, data: cpu_data_wdata, size: cpu_data_size});
        mcount++; mpend = 1;
      end
      if (acc && !cpu_data_wr) begin
        rd_busy = 1; mpend = 1; rd_addr_m = cpu_data_addr; rd_size_m = cpu_data_size;
      end
    end
  end

  // Memory responder: random 0-5 cycle address and data latency; stalls on demand.
  bit          mem_stall = 0, data_stall = 0;
  bit          hs_a, hs_d, rs, s_wr, busy = 0, c_wr = 0;
  logic [31:0] s_addr, s_data, c_addr = '0, c_data = '0;
  int          adly = 0, ddly = 0;

  initial begin
    mem_data_addr_ok = 0; mem_data_data_ok = 0; mem_data_rdata = '0;
    forever begin
      @(negedge clk);
      hs_a = mem_data_req && mem_data_addr_ok; hs_d = mem_data_data_ok; rs = resetn;
      s_wr = mem_data_wr; s_addr = mem_data_addr; s_data = mem_data_wdata;
      @(posedge clk); #2;
      if (!rs) begin
        busy = 0; mem_data_addr_ok = 0; mem_data_data_ok = 0; mem_data_rdata = '0;
        adly = $urandom_range(0, 5);
      end else begin
        if (hs_d) begin
          if (c_wr) mem_model[c_addr] = c_data;
          busy = 0; mem_data_data_ok = 0; mem_data_rdata = '0;
        end
        if (hs_a) begin
          busy = 1; mem_data_addr_ok = 0;
          c_wr = s_wr; c_addr = s_addr; c_data = s_data;
          ddly = $urandom_range(0, 5); adly = $urandom_range(0, 5);
        end
        if (busy) begin
          if (!mem_data_data_ok && !data_stall) begin
            if (ddly == 0) begin
              mem_data_data_ok = 1;
              mem_data_rdata = c_wr ? $urandom : memget(c_addr);
            end else ddly--;
          end
        end else if (mem_data_req && !mem_stall) begin
          if (adly == 0) mem_data_addr_ok = 1; else adly--;
        end else mem_data_addr_ok = 0;
      end
    end
  end

  task automatic wait_acc();
    int n = 0;
    forever begin
      @(negedge clk);
      if (cpu_data_addr_ok) break;
      n++;
      if (n > 300) begin chk("acc_timeout", cpu_data_addr_ok, 1'b1); break; end
    end
    @(posedge clk); #1;
    cpu_data_req = 0;
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    cpu_data_req = 1; cpu_data_wr = wr; cpu_data_addr = a; cpu_data_wdata = d; cpu_data_size = sz;
    wait_acc();
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (mcount == 0 && !mpend && !rd_busy) break;
      n++;
      if (n > 1000) begin chk("drain_timeout", wb_empty, 1'b1); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_data_req = 0; cpu_data_wr = 0; cpu_data_size = '0; cpu_data_addr = '0; cpu_data_wdata = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("rst_mem_req", mem_data_req, 0);
    chk("rst_mem_wr", mem_data_wr, 0);
    chk("rst_mem_addr", mem_data_addr, 0);
    chk("rst_mem_wdata", mem_data_wdata, 0);
    chk("rst_mem_size", mem_data_size, 0);
    chk("rst_data_ok", cpu_data_data_ok, 0);
    chk("rst_rdata", cpu_data_rdata, 0);
    chk("rst_empty", wb_empty, 1);
    chk("rst_full", wb_full, 0);
    @(posedge clk); #1;

    // single store, then drain
    do_req(1, 32'h1000_0010, 32'hDEAD_BEEF, 2'd2);
    drain();
    @(negedge clk);
    chk("single_empty", wb_empty, 1);
    @(posedge clk); #1;

    // fill with the memory stalled; the fifth store must wait for a slot
    mem_stall = 1;
    for (int i = 0; i < 4; i++) do_req(1, 32'h200 + 4 * i, $urandom, 2'd2);
    @(negedge clk);
    chk("fill_full", wb_full, 1);
    @(posedge clk); #1;
    cpu_data_req = 1; cpu_data_wr = 1; cpu_data_addr = 32'h210; cpu_data_wdata = 32'h5; cpu_data_size = 2'd2;
    repeat (5) begin
      @(negedge clk);
      chk("fifth_held", cpu_data_addr_ok, 0);
    end
    @(posedge clk); #1;
    mem_stall = 0;
    wait_acc();
    drain();

    // read-after-write returns the stored value
    do_req(1, 32'h20, 32'h55, 2'd2);
    do_req(0, 32'h20, 32'h0, 2'd2);
    drain();
    chk("raw_rdata", last_rdata, 32'h55);

    // reset while the head store is outstanding with three buffered
    data_stall = 1;
    for (int i = 0; i < 3; i++) do_req(1, 32'h300 + 4 * i, $urandom, 2'd2);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out && mcount == 3) break;
    end
    chk("rst_setup_wb_full_n", wb_full, 0);
    @(posedge clk); #1 resetn = 0;
    @(posedge clk); #1 resetn = 1; data_stall = 0;
    @(negedge clk);
    chk("midrst_mem_req", mem_data_req, 0);
    chk("midrst_empty", wb_empty, 1);
    chk("midrst_data_ok", cpu_data_data_ok, 0);
    @(posedge clk); #1;

    // random traffic over a small address window so reads hit earlier stores
    for (int k = 0; k < 300; k++) begin
      do_req(($urandom % 4) != 0, 32'h100 + 4 * $urandom_range(0, 7), $urandom, 2'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    @(negedge clk);
    chk("final_empty", wb_empty, 1);
    chk("final_issued", mq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
